// File: rtl/cache_mem_if.sv
// Cache <-> memory line interface.
// One 128-bit line per request, completed by a one-cycle ready pulse.
interface cache_mem_if;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Slow backing memory behind the L1 cache.
// Serves one line read/write at a time after LATENCY cycles.
module cache_mem_responder #(
  parameter int IDX_W   = 6,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_mem_if.slave       bus,
  output logic             proto_err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [127:0]       wdata_q, wdata_d;
  logic [127:0]       rdata_q;
  logic               ready_q;
  logic               perr_q;
  logic [CNT_W-1:0]   rdc_q, wrc_q;
  logic [127:0]       store_q [DEPTH];
  logic               req;
  logic               accept;
  logic               unused_addr;

  assign req         = bus.mem_read | bus.mem_write;
  assign unused_addr = ^bus.mem_addr[27:IDX_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          accept  = 1'b1;
          wr_d    = bus.mem_write;
          idx_d   = bus.mem_addr[IDX_W-1:0];
          wdata_d = bus.mem_wdata;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        // Cache dropping both strobes cancels the request.
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_d == 8'd0) state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      perr_q  <= 1'b0;
      rdc_q   <= '0;
      wrc_q   <= '0;
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ready_q <= (state_d == S_RESP);
      if (state_d == S_RESP && !wr_d)
        rdata_q <= store_q[idx_d];
      if (accept && bus.mem_read && bus.mem_write)
        perr_q <= 1'b1;
      // Commit and count at the end of the ready cycle.
      if (state_q == S_RESP) begin
        if (wr_q) begin
          store_q[idx_q] <= wdata_q;
          if (wrc_q != CMAX) wrc_q <= wrc_q + 1'b1;
        end else begin
          if (rdc_q != CMAX) rdc_q <= rdc_q + 1'b1;
        end
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ready = ready_q;
  assign proto_err     = perr_q;
  assign rd_count      = rdc_q;
  assign wr_count      = wrc_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: vector table, scoreboard,
// abort/reset sequences and a LATENCY=1, CNT_W=2 instance.
module tb_cache_mem_responder;

  localparam int LAT = 4;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] erdata;
    logic         eperr;
    logic [15:0]  erd;
    logic [15:0]  ewr;
    logic         b2b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_mem_if bus ();
  cache_mem_if bus2 ();

  logic        perr, perr2;
  logic [15:0] rdc, wrc;
  logic [1:0]  rdc2, wrc2;

  cache_mem_responder #(
    .IDX_W(6), .LATENCY(LAT), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .proto_err(perr), .rd_count(rdc), .wr_count(wrc)
  );

  cache_mem_responder #(
    .IDX_W(6), .LATENCY(1), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .proto_err(perr2), .rd_count(rdc2), .wr_count(wrc2)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int rdy1 = 0;
  int last_rdy = 0;
  logic prev1 = 1'b0;
  logic prev2 = 1'b0;
  int rc2[$];
  logic [127:0] sb[$];
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_ready === 1'b1) begin
      rdy1++;
      chk("ready_repeat", 128'(prev1), 128'd0);
    end
    prev1 = (bus.mem_ready === 1'b1);
    if (bus2.mem_ready === 1'b1) begin
      rc2.push_back(cyc);
      chk("ready2_repeat", 128'(prev2), 128'd0);
    end
    prev2 = (bus2.mem_ready === 1'b1);
  end

  task automatic run_vec(input vec_t v, input string nm);
    int acc;
    int k;
    bit got;
    logic [127:0] e;
    got = 1'b0;
    k = 0;
    bus.mem_read  = v.rd;
    bus.mem_write = v.wr;
    bus.mem_addr  = v.addr;
    bus.mem_wdata = v.wdata;
    acc = cyc;
    if (v.rd && !v.wr) sb.push_back(v.erdata);
    @(negedge clk);
    chk({nm, "_early"}, 128'(bus.mem_ready), 128'd0);
    @(posedge clk); #1;
    bus.mem_addr  = ~v.addr;
    bus.mem_wdata = ~v.wdata;
    while (!got && k < 20) begin
      @(negedge clk);
      got = (bus.mem_ready === 1'b1);
      k++;
    end
    chk({nm, "_ready_seen"}, 128'(got), 128'd1);
    if (got) begin
      chk({nm, "_latency"}, 128'(cyc - acc), 128'(LAT));
      if (v.b2b) chk({nm, "_gap"}, 128'(cyc - last_rdy), 128'(LAT + 1));
      last_rdy = cyc;
      chk({nm, "_perr"}, 128'(perr), 128'(v.eperr));
    end
    if (v.rd && !v.wr) begin
      e = sb.pop_front();
      if (got) chk({nm, "_rdata"}, bus.mem_rdata, e);
    end
    @(posedge clk); #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    chk({nm, "_rd_count"}, 128'(rdc), 128'(v.erd));
    chk({nm, "_wr_count"}, 128'(wrc), 128'(v.ewr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int acc2;
    int n;
    int k;
    vec_t v;

    tbl[0] = '{1'b1, 1'b0, 28'h0000005, 128'h0, 128'h0,
               1'b0, 16'd1, 16'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 28'h0000012,
               128'hDEADBEEF_00000003_00000002_00000001, 128'h0,
               1'b0, 16'd1, 16'd1, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 28'h0000012, 128'h0,
               128'hDEADBEEF_00000003_00000002_00000001,
               1'b0, 16'd2, 16'd1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 28'h0000003,
               128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 128'h0,
               1'b0, 16'd2, 16'd2, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 28'h0000007, 128'h0, 128'h0,
               1'b0, 16'd3, 16'd2, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 28'h0000043, 128'h0,
               128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0,
               1'b0, 16'd4, 16'd2, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 28'h0000001, {128{1'b1}}, 128'h0,
               1'b1, 16'd4, 16'd3, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 28'h0000001, 128'h0, {128{1'b1}},
               1'b1, 16'd5, 16'd3, 1'b1};

    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus2.mem_read  = 1'b0;
    bus2.mem_write = 1'b0;
    bus2.mem_addr  = '0;
    bus2.mem_wdata = '0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 128'(bus.mem_ready), 128'd0);
    chk("rst_rdata", bus.mem_rdata, 128'd0);
    chk("rst_perr", 128'(perr), 128'd0);
    chk("rst_rd_count", 128'(rdc), 128'd0);
    chk("rst_wr_count", 128'(wrc), 128'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Abort: request dropped while waiting.
    n0 = rdy1;
    bus.mem_read = 1'b1;
    bus.mem_addr = 28'h0000002;
    repeat (2) @(posedge clk);
    #1 bus.mem_read = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_ready", 128'(rdy1 - n0), 128'd0);
    chk("abort_rd_count", 128'(rdc), 128'd5);
    chk("abort_wr_count", 128'(wrc), 128'd3);
    chk("abort_perr_sticky", 128'(perr), 128'd1);

    // Reset in the middle of a write wait.
    @(posedge clk); #1;
    n0 = rdy1;
    bus.mem_write = 1'b1;
    bus.mem_addr  = 28'h0000004;
    bus.mem_wdata = 128'h12345678_9ABCDEF0_CAFEF00D_0BADBEEF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.mem_write = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_ready", 128'(rdy1 - n0), 128'd0);
    chk("rst_mid_perr", 128'(perr), 128'd0);
    chk("rst_mid_rd_count", 128'(rdc), 128'd0);
    chk("rst_mid_wr_count", 128'(wrc), 128'd0);
    @(posedge clk); #1;
    v = '{1'b1, 1'b0, 28'h0000004, 128'h0, 128'h0,
          1'b0, 16'd1, 16'd0, 1'b0};
    run_vec(v, "rd_after_rst");
    chk("sb_empty", 128'(sb.size()), 128'd0);

    // LATENCY=1 instance: continuous reads, counter saturation.
    @(posedge clk); #1;
    rc2.delete();
    acc2 = cyc;
    bus2.mem_read = 1'b1;
    bus2.mem_addr = 28'h0000009;
    n = 0;
    k = 0;
    while (n < 5 && k < 30) begin
      @(negedge clk);
      if (bus2.mem_ready === 1'b1) n++;
      k++;
    end
    chk("l1_five_readies", 128'(n), 128'd5);
    @(posedge clk); #1;
    bus2.mem_read = 1'b0;
    repeat (3) @(negedge clk);
    if (rc2.size() >= 3) begin
      chk("l1_ready0", 128'(rc2[0] - acc2), 128'd1);
      chk("l1_ready1", 128'(rc2[1] - acc2), 128'd3);
      chk("l1_ready2", 128'(rc2[2] - acc2), 128'd5);
    end else begin
      chk("l1_ready_stamps", 128'(rc2.size()), 128'd5);
    end
    chk("l1_rd_count_sat", 128'(rdc2), 128'd3);
    chk("l1_wr_count", 128'(wrc2), 128'd0);
    chk("l1_perr", 128'(perr2), 128'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
